// File: rtl/obuf_pkg.sv
// obuf_pkg: shared types and helpers for the multi-tag output buffer.
//   tag_state_e : lifecycle of one ping-pong tag set
//   tag_w()     : width of a tag pointer (never below 1 bit)
package obuf_pkg;

    typedef enum logic [1:0] {
        TAG_FREE    = 2'd0,
        TAG_COMPUTE = 2'd1,
        TAG_READY   = 2'd2,
        TAG_DRAIN   = 2'd3
    } tag_state_e;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obuf_bank.sv
// obuf_bank: one 1W1R storage bank, DEPTH x DATA_W, registered read with
// RD_LAT cycles of latency.
//   clk          : rising-edge clock
//   we/waddr/wdata : write port
//   re/raddr     : read strobe and address
//   rdata        : word read RD_LAT cycles after re; holds stale data when
//                  no read is in flight (the top gates it)
// A same-cycle write and read of one address returns the old word, since the
// read samples the array before the write's non-blocking update lands.
module obuf_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] q_pipe [RD_LAT:1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) q_pipe[1] <= mem[raddr];
        for (int s = 2; s <= RD_LAT; s++) q_pipe[s] <= q_pipe[s-1];
    end

    assign rdata = q_pipe[RD_LAT];

endmodule

// File: rtl/obuf_multitag.sv
// obuf_multitag: output buffer with NUM_TAGS ping-pong tag sets of ARRAY_M
// banks each. The compute side claims a FREE tag, writes/accumulates into it,
// then closes it (READY); the drain side claims a READY tag, reads it out and
// releases it (FREE).
//   clk, reset                 : clock, synchronous active-high reset
//   arr_wr_* / arr_rd_*        : per-bank array write and read (compute tag)
//   dr_rd_*                    : per-bank drain read (drain tag)
//   cmp_start/cmp_ready/cmp_done : compute tag handshake
//   dr_start/dr_valid/dr_done    : drain tag handshake
//   cmp_tag, dr_tag            : current compute / drain pointers
//   err                        : registered one-cycle protocol-violation pulse,
//                                asserted the cycle after the offending input
module obuf_multitag
    import obuf_pkg::*;
#(
    parameter int NUM_TAGS = 2,
    parameter int ARRAY_M  = 16,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RD_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ARRAY_M-1:0]          arr_wr_req,
    input  logic [ARRAY_M*ADDR_W-1:0]   arr_wr_addr,
    input  logic [ARRAY_M*DATA_W-1:0]   arr_wr_data,
    input  logic [ARRAY_M-1:0]          arr_rd_req,
    input  logic [ARRAY_M*ADDR_W-1:0]   arr_rd_addr,
    output logic [ARRAY_M*DATA_W-1:0]   arr_rd_data,
    input  logic [ARRAY_M-1:0]          dr_rd_req,
    input  logic [ARRAY_M*ADDR_W-1:0]   dr_rd_addr,
    output logic [ARRAY_M*DATA_W-1:0]   dr_rd_data,
    input  logic                        cmp_start,
    output logic                        cmp_ready,
    input  logic                        cmp_done,
    input  logic                        dr_start,
    output logic                        dr_valid,
    input  logic                        dr_done,
    output logic [tag_w(NUM_TAGS)-1:0]  cmp_tag,
    output logic [tag_w(NUM_TAGS)-1:0]  dr_tag,
    output logic                        err
);

    localparam int              TW       = tag_w(NUM_TAGS);
    localparam logic [TW-1:0]   LAST_TAG = TW'(NUM_TAGS - 1);

    // One in-flight read per lane: which tag it was issued against.
    typedef struct packed {
        logic          vld;
        logic [TW-1:0] tag;
    } rd_trk_t;

    function automatic logic [TW-1:0] nxt_tag(input logic [TW-1:0] t);
        return (t == LAST_TAG) ? '0 : t + TW'(1);
    endfunction

    // ---------------- tag lifecycle ----------------
    tag_state_e    state_q [NUM_TAGS];
    tag_state_e    state_d [NUM_TAGS];
    logic [TW-1:0] cmp_ptr_q, cmp_ptr_d, dr_ptr_q, dr_ptr_d;
    logic          cmp_act_q, cmp_act_d, dr_act_q, dr_act_d;
    logic          err_q, err_d;
    logic          cmp_claim, cmp_close, dr_claim, dr_close;

    // Readiness comes from registered state only, so a tag released this
    // cycle cannot be re-claimed until the next one.
    assign cmp_ready = (state_q[cmp_ptr_q] == TAG_FREE);
    assign dr_valid  = (state_q[dr_ptr_q]  == TAG_READY);

    assign cmp_claim = cmp_start && cmp_ready && !cmp_act_q;
    assign cmp_close = cmp_done  && cmp_act_q;
    assign dr_claim  = dr_start  && dr_valid  && !dr_act_q;
    assign dr_close  = dr_done   && dr_act_q;

    always_comb begin
        state_d   = state_q;
        cmp_ptr_d = cmp_ptr_q;
        dr_ptr_d  = dr_ptr_q;
        cmp_act_d = cmp_act_q;
        dr_act_d  = dr_act_q;
        err_d     = (cmp_start && !cmp_claim) || (cmp_done && !cmp_act_q) ||
                    (dr_start  && !dr_claim)  || (dr_done  && !dr_act_q)  ||
                    (!cmp_act_q && ((|arr_wr_req) || (|arr_rd_req)))      ||
                    (!dr_act_q  && (|dr_rd_req));

        // Each event touches a distinct tag, so the order here is immaterial.
        if (cmp_claim) begin
            state_d[cmp_ptr_q] = TAG_COMPUTE;
            cmp_act_d          = 1'b1;
        end
        if (cmp_close) begin
            state_d[cmp_ptr_q] = TAG_READY;
            cmp_act_d          = 1'b0;
            cmp_ptr_d          = nxt_tag(cmp_ptr_q);
        end
        if (dr_claim) begin
            state_d[dr_ptr_q] = TAG_DRAIN;
            dr_act_d          = 1'b1;
        end
        if (dr_close) begin
            state_d[dr_ptr_q] = TAG_FREE;
            dr_act_d          = 1'b0;
            dr_ptr_d          = nxt_tag(dr_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_TAGS; t++) state_q[t] <= TAG_FREE;
            cmp_ptr_q <= '0;
            dr_ptr_q  <= '0;
            cmp_act_q <= 1'b0;
            dr_act_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmp_ptr_q <= cmp_ptr_d;
            dr_ptr_q  <= dr_ptr_d;
            cmp_act_q <= cmp_act_d;
            dr_act_q  <= dr_act_d;
            err_q     <= err_d;
        end
    end

    assign cmp_tag = cmp_ptr_q;
    assign dr_tag  = dr_ptr_q;
    assign err     = err_q;

    // ---------------- read tracking ----------------
    // The tag is latched at request time so data still returns from the
    // right bank if the tag is closed or released while the read is in flight.
    rd_trk_t [ARRAY_M-1:0] arr_req, dr_req;
    rd_trk_t [ARRAY_M-1:0] arr_pipe [RD_LAT:1];
    rd_trk_t [ARRAY_M-1:0] dr_pipe  [RD_LAT:1];
    logic    [DATA_W-1:0]  bank_q   [NUM_TAGS][ARRAY_M];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 1; s <= RD_LAT; s++) begin
                arr_pipe[s] <= '0;
                dr_pipe[s]  <= '0;
            end
        end else begin
            arr_pipe[1] <= arr_req;
            dr_pipe[1]  <= dr_req;
            for (int s = 2; s <= RD_LAT; s++) begin
                arr_pipe[s] <= arr_pipe[s-1];
                dr_pipe[s]  <= dr_pipe[s-1];
            end
        end
    end

    for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
        assign arr_req[m] = '{vld: cmp_act_q && arr_rd_req[m], tag: cmp_ptr_q};
        assign dr_req[m]  = '{vld: dr_act_q  && dr_rd_req[m],  tag: dr_ptr_q};

        assign arr_rd_data[m*DATA_W +: DATA_W] =
            arr_pipe[RD_LAT][m].vld ? bank_q[arr_pipe[RD_LAT][m].tag][m] : '0;
        assign dr_rd_data[m*DATA_W +: DATA_W] =
            dr_pipe[RD_LAT][m].vld ? bank_q[dr_pipe[RD_LAT][m].tag][m] : '0;
    end

    // ---------------- banks ----------------
    // A tag is never COMPUTE and DRAIN at once, so each bank sees at most one
    // of the two read ports in a cycle and a single read port suffices.
    for (genvar t = 0; t < NUM_TAGS; t++) begin : g_tag
        logic csel, dsel;
        assign csel = cmp_act_q && (cmp_ptr_q == TW'(t));
        assign dsel = dr_act_q  && (dr_ptr_q  == TW'(t));

        for (genvar m = 0; m < ARRAY_M; m++) begin : g_bank
            logic are, dre;
            assign are = csel && arr_rd_req[m];
            assign dre = dsel && dr_rd_req[m];

            obuf_bank #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .ADDR_W (ADDR_W),
                .RD_LAT (RD_LAT)
            ) u_bank (
                .clk   (clk),
                .we    (csel && arr_wr_req[m]),
                .waddr (arr_wr_addr[m*ADDR_W +: ADDR_W]),
                .wdata (arr_wr_data[m*DATA_W +: DATA_W]),
                .re    (are || dre),
                .raddr (are ? arr_rd_addr[m*ADDR_W +: ADDR_W]
                            : dr_rd_addr[m*ADDR_W +: ADDR_W]),
                .rdata (bank_q[t][m])
            );
        end
    end

endmodule

// File: tb/tb_obuf_multitag.sv
// tb_obuf_multitag: directed scenarios followed by randomized traffic, every
// cycle compared against a tag-lifecycle / memory reference model.
module tb_obuf_multitag;

    localparam int NUM_TAGS = 2;
    localparam int ARRAY_M  = 16;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 64;
    localparam int ADDR_W   = 6;
    localparam int RD_LAT   = 2;
    localparam int TW       = 1;
    localparam int BW       = ARRAY_M * DATA_W;

    localparam int S_FREE = 0, S_COMP = 1, S_READY = 2, S_DRAIN = 3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [ARRAY_M-1:0]        arr_wr_req, arr_rd_req, dr_rd_req;
    logic [ARRAY_M*ADDR_W-1:0] arr_wr_addr, arr_rd_addr, dr_rd_addr;
    logic [BW-1:0]             arr_wr_data;
    logic [BW-1:0]             arr_rd_data, dr_rd_data;
    logic                      cmp_start, cmp_ready, cmp_done;
    logic                      dr_start, dr_valid, dr_done;
    logic [TW-1:0]             cmp_tag, dr_tag;
    logic                      err;

    obuf_multitag #(
        .NUM_TAGS (NUM_TAGS), .ARRAY_M (ARRAY_M), .DATA_W (DATA_W),
        .DEPTH (DEPTH), .ADDR_W (ADDR_W), .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk), .reset (reset),
        .arr_wr_req (arr_wr_req), .arr_wr_addr (arr_wr_addr), .arr_wr_data (arr_wr_data),
        .arr_rd_req (arr_rd_req), .arr_rd_addr (arr_rd_addr), .arr_rd_data (arr_rd_data),
        .dr_rd_req (dr_rd_req), .dr_rd_addr (dr_rd_addr), .dr_rd_data (dr_rd_data),
        .cmp_start (cmp_start), .cmp_ready (cmp_ready), .cmp_done (cmp_done),
        .dr_start (dr_start), .dr_valid (dr_valid), .dr_done (dr_done),
        .cmp_tag (cmp_tag), .dr_tag (dr_tag), .err (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit                mdl_ok = 0;
    int                mst [NUM_TAGS];
    int                mcp, mdp;
    bit                mca, mda, merr;
    logic [DATA_W-1:0] mmem   [NUM_TAGS][ARRAY_M][DEPTH];
    bit                mknown [NUM_TAGS][ARRAY_M][DEPTH];
    // Expected read outputs by age; mask bits clear where the word is unknown.
    logic [BW-1:0]     ea_v [RD_LAT:1], ea_m [RD_LAT:1];
    logic [BW-1:0]     ed_v [RD_LAT:1], ed_m [RD_LAT:1];

    task automatic mdl_step();
        logic [BW-1:0] nav, nam, ndv, ndm;
        bit cc, cx, dc, dx;
        int a;
        if (reset) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                mst[t] = S_FREE;
                for (int m = 0; m < ARRAY_M; m++)
                    for (int d = 0; d < DEPTH; d++) mknown[t][m][d] = 0;
            end
            mcp = 0; mdp = 0; mca = 0; mda = 0; merr = 0;
            for (int s = 1; s <= RD_LAT; s++) begin
                ea_v[s] = '0; ea_m[s] = '1; ed_v[s] = '0; ed_m[s] = '1;
            end
            mdl_ok = 1;
            return;
        end
        nav = '0; nam = '1; ndv = '0; ndm = '1;
        for (int m = 0; m < ARRAY_M; m++) begin
            if (arr_rd_req[m] && mca) begin
                a = int'(arr_rd_addr[m*ADDR_W +: ADDR_W]);
                if (mknown[mcp][m][a]) nav[m*DATA_W +: DATA_W] = mmem[mcp][m][a];
                else                   nam[m*DATA_W +: DATA_W] = '0;
            end
            if (dr_rd_req[m] && mda) begin
                a = int'(dr_rd_addr[m*ADDR_W +: ADDR_W]);
                if (mknown[mdp][m][a]) ndv[m*DATA_W +: DATA_W] = mmem[mdp][m][a];
                else                   ndm[m*DATA_W +: DATA_W] = '0;
            end
        end
        for (int s = RD_LAT; s > 1; s--) begin
            ea_v[s] = ea_v[s-1]; ea_m[s] = ea_m[s-1];
            ed_v[s] = ed_v[s-1]; ed_m[s] = ed_m[s-1];
        end
        ea_v[1] = nav; ea_m[1] = nam; ed_v[1] = ndv; ed_m[1] = ndm;
        for (int m = 0; m < ARRAY_M; m++) begin
            if (arr_wr_req[m] && mca) begin
                a = int'(arr_wr_addr[m*ADDR_W +: ADDR_W]);
                mmem[mcp][m][a]   = arr_wr_data[m*DATA_W +: DATA_W];
                mknown[mcp][m][a] = 1;
            end
        end
        cc = cmp_start && !mca && (mst[mcp] == S_FREE);
        cx = cmp_done && mca;
        dc = dr_start && !mda && (mst[mdp] == S_READY);
        dx = dr_done && mda;
        merr = (cmp_start && !cc) || (cmp_done && !mca) || (dr_start && !dc) ||
               (dr_done && !mda) || (!mca && ((|arr_wr_req) || (|arr_rd_req))) ||
               (!mda && (|dr_rd_req));
        if (cc) begin mst[mcp] = S_COMP; mca = 1; end
        if (cx) begin mst[mcp] = S_READY; mca = 0; mcp = (mcp + 1) % NUM_TAGS; end
        if (dc) begin mst[mdp] = S_DRAIN; mda = 1; end
        if (dx) begin mst[mdp] = S_FREE; mda = 0; mdp = (mdp + 1) % NUM_TAGS; end
    endtask

    // One clock: check every output at the falling edge, advance the model,
    // then return just after the rising edge so the caller can drive inputs.
    task automatic cycle();
        @(negedge clk);
        if (mdl_ok) begin
            chk("cmp_ready", BW'(cmp_ready), BW'(mst[mcp] == S_FREE));
            chk("dr_valid",  BW'(dr_valid),  BW'(mst[mdp] == S_READY));
            chk("cmp_tag",   BW'(cmp_tag),   BW'(mcp));
            chk("dr_tag",    BW'(dr_tag),    BW'(mdp));
            chk("err",       BW'(err),       BW'(merr));
            chk("arr_rd_data", arr_rd_data & ea_m[RD_LAT], ea_v[RD_LAT] & ea_m[RD_LAT]);
            chk("dr_rd_data",  dr_rd_data  & ed_m[RD_LAT], ed_v[RD_LAT] & ed_m[RD_LAT]);
        end
        mdl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset = 1'b0;
        arr_wr_req = '0; arr_rd_req = '0; dr_rd_req = '0;
        arr_wr_addr = '0; arr_rd_addr = '0; dr_rd_addr = '0; arr_wr_data = '0;
        cmp_start = 1'b0; cmp_done = 1'b0; dr_start = 1'b0; dr_done = 1'b0;
    endtask

    task automatic wr(input int m, input int a, input logic [DATA_W-1:0] d);
        arr_wr_req[m] = 1'b1;
        arr_wr_addr[m*ADDR_W +: ADDR_W] = ADDR_W'(a);
        arr_wr_data[m*DATA_W +: DATA_W] = d;
    endtask

    task automatic ard(input int m, input int a);
        arr_rd_req[m] = 1'b1;
        arr_rd_addr[m*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic drd(input int m, input int a);
        dr_rd_req[m] = 1'b1;
        dr_rd_addr[m*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    function automatic logic [BW-1:0] lane(input logic [BW-1:0] v, input int m);
        return BW'(v[m*DATA_W +: DATA_W]);
    endfunction

    initial begin
        clr();
        reset = 1'b1;
        cycle(); cycle();
        clr();
        chk("rst_ready", BW'(cmp_ready), BW'(1));
        chk("rst_valid", BW'(dr_valid), BW'(0));
        chk("rst_err",   BW'(err), BW'(0));

        // write/drain round trip, then compute tag1 alongside drain of tag0
        cmp_start = 1'b1; cycle(); clr();
        wr(0, 5, 32'hA5); cycle(); clr();
        cmp_done = 1'b1; cycle(); clr();
        dr_start = 1'b1; cmp_start = 1'b1; cycle(); clr();
        wr(0, 5, 32'h5A); cycle(); clr();
        drd(0, 5); ard(0, 5); cycle(); clr();
        repeat (RD_LAT - 1) cycle();
        chk("drain_a5", lane(dr_rd_data, 0), BW'(32'hA5));
        chk("arr_5a",   lane(arr_rd_data, 0), BW'(32'h5A));
        chk("dr_tag0",  BW'(dr_tag), BW'(0));
        chk("cmp_tag1", BW'(cmp_tag), BW'(1));
        cmp_done = 1'b1; dr_done = 1'b1; cycle(); clr();
        chk("cmp_wrap", BW'(cmp_tag), BW'(0));
        chk("dr_adv",   BW'(dr_tag), BW'(1));
        dr_start = 1'b1; cycle(); clr();
        dr_done = 1'b1; cycle(); clr();
        chk("dr_wrap", BW'(dr_tag), BW'(0));

        // fill both tags with no drain: third claim refused
        repeat (2) begin
            cmp_start = 1'b1; cycle(); clr();
            cmp_done = 1'b1; cycle(); clr();
        end
        chk("full_ready", BW'(cmp_ready), BW'(0));
        cmp_start = 1'b1; cycle(); clr();
        chk("full_err",   BW'(err), BW'(1));
        chk("full_tag",   BW'(cmp_tag), BW'(0));
        chk("full_ready2", BW'(cmp_ready), BW'(0));

        // release and claim of tag0 in one cycle: claim refused, retry works
        dr_start = 1'b1; cycle(); clr();
        dr_done = 1'b1; cmp_start = 1'b1; cycle(); clr();
        chk("rel_claim_err", BW'(err), BW'(1));
        chk("rel_ready",     BW'(cmp_ready), BW'(1));
        cmp_start = 1'b1; cycle(); clr();
        chk("retry_err",   BW'(err), BW'(0));
        chk("retry_ready", BW'(cmp_ready), BW'(0));

        // read-first on same-cycle write/read of one address
        wr(2, 7, 32'h11); cycle(); clr();
        wr(2, 7, 32'h33); ard(2, 7); cycle(); clr();
        ard(2, 7); cycle(); clr();
        repeat (RD_LAT - 2) cycle();
        chk("rf_old", lane(arr_rd_data, 2), BW'(32'h11));
        cycle();
        chk("rf_new", lane(arr_rd_data, 2), BW'(32'h33));
        cmp_done = 1'b1; cycle(); clr();

        // reset while draining tag1 with a read in flight
        dr_start = 1'b1; cycle(); clr();
        drd(0, 5); cycle(); clr();
        reset = 1'b1; cycle(); clr();
        chk("rst_drd",   lane(dr_rd_data, 0), BW'(0));
        chk("rst_dval",  BW'(dr_valid), BW'(0));
        chk("rst_cready", BW'(cmp_ready), BW'(1));
        chk("rst_drtag", BW'(dr_tag), BW'(0));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clr();
            reset     = ($urandom_range(0, 199) == 0);
            cmp_start = ($urandom_range(0, 4) == 0);
            cmp_done  = ($urandom_range(0, 5) == 0);
            dr_start  = ($urandom_range(0, 4) == 0);
            dr_done   = ($urandom_range(0, 5) == 0);
            for (int m = 0; m < ARRAY_M; m++) begin
                if ($urandom_range(0, 3) == 0 && (mca || $urandom_range(0, 9) == 0))
                    wr(m, int'($urandom_range(0, 7)), $urandom);
                if ($urandom_range(0, 3) == 0 && (mca || $urandom_range(0, 9) == 0))
                    ard(m, int'($urandom_range(0, 7)));
                if ($urandom_range(0, 3) == 0 && (mda || $urandom_range(0, 9) == 0))
                    drd(m, int'($urandom_range(0, 7)));
            end
            cycle();
        end
        clr();
        repeat (RD_LAT + 1) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
